match_count_arbiter: RTL
========================

# match_count_arbiter

Round-robin arbiter that shares the single match counter between `NUM_REQ` independent match channels. Each channel raises a request while it holds a match; the arbiter grants one channel at a time, asserts `enable_count` for every granted cycle, and freezes all grants while `halt_flag` is high. It sits between the per-channel match detectors and the shared counter, and uses the same IDLE/MATCH/HALT state encoding as the existing control path.

## Interface
- `NUM_REQ`, 4: number of requesting channels (2..16).
- `ID_W`, 2: width of `grant_id`; must satisfy 2^ID_W >= NUM_REQ.
- `MAX_HOLD`, 8: maximum grant tenure in cycles when the hold limit is compiled in (>= 1).

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset: asserted at 0, released at 1.
- `halt_flag`  in  1  global halt; freezes arbitration while high.
- `req`  in  NUM_REQ  per-channel request, level; bit i = channel i.
- `grant`  out  NUM_REQ  one-hot grant, registered; all-zero when nothing is granted.
- `grant_id`  out  ID_W  binary index of the granted channel; holds the last winner when `grant` = 0.
- `state`  out  2  FSM state: IDLE=2'b00, MATCH=2'b01, HALT=2'b10.
- `enable_count`  out  1  shared-counter enable; equals (state == MATCH).

## Operation
- Reset (`reset` = 0): state=IDLE, grant=0, grant_id=0, enable_count=0, round-robin pointer rr_ptr=0, tenure=0. Takes effect immediately and overrides any in-progress grant.
- Winner selection: the first channel with req=1, searching upward from rr_ptr and wrapping NUM_REQ-1 → 0.
- IDLE: if halt_flag → HALT; else if any req → MATCH, grant the winner; else stay in IDLE.
- MATCH, checked in priority order:
  - halt_flag=1 → HALT, grant=0. Halt takes priority over everything else.
  - granted channel's req=0 → release.
  - Forced release by the hold limit (see Configuration) → release.
  - Otherwise keep the same grant and increment tenure.
- Release: rr_ptr ← (winner+1) mod NUM_REQ.
  - If other reqs are pending, re-arbitrate in the same cycle: stay in MATCH and grant the new winner back-to-back with no idle cycle.
  - If no reqs are pending → IDLE, grant=0.
- HALT: grant=0. When halt_flag=0 → IDLE; requests are re-arbitrated from IDLE on the following cycle.
- Tenure counter: set to 1 on each new grant, saturates at MAX_HOLD.
- Pointer rule: rr_ptr changes only on release, never on halt. A grant cut off by halt does not advance the pointer, so that channel wins first after the halt clears if it is still requesting.
- Invalid state encoding 2'b11 → IDLE next cycle.

## Timing
- All outputs are registered.
- A req rising at edge k (sampled at edge k) produces grant/grant_id/enable_count high after edge k, i.e. visible one cycle later.
- A granted channel dropping req at edge k: its grant is low after edge k. A new winner's grant is high after the same edge k.
- halt_flag sampled high at edge k: grant=0 and enable_count=0 after edge k.
- Exactly one enable_count cycle per MATCH cycle. `grant` is never more than one-hot.

## Configuration
- Macro: `MATCH_ARB_HOLD_LIMIT_EN`.
- Defined: when tenure == MAX_HOLD and at least one other channel is requesting, force a release at that edge. The channel then re-requests like any other.
  - If no other channel is requesting, the grant continues and tenure stays saturated.
- Undefined: no forced release; the winner holds the grant until its req drops or a halt occurs. MAX_HOLD and the tenure counter have no effect.

## Test plan
- Reset: hold reset=0 with req=4'b1111 → state=00, grant=0, grant_id=0, enable_count=0. Release reset → grant=4'b0001 one cycle later.
- Round-robin: req=4'b1010 held, each granted channel drops req after 2 cycles then re-raises it → grants ch1, ch3, ch1 back-to-back; enable_count stays 1 with no gap.
- Halt mid-grant: ch2 granted, then halt_flag=1 for 3 cycles → state=10, grant=0, enable_count=0. Clear halt → IDLE for one cycle, then ch2 granted again (pointer not advanced).
- Wrap-around: rr_ptr=3 and req=4'b1001 → ch3 granted. On release → ch0 granted, grant_id=0.
- Hold limit with macro defined, MAX_HOLD=4, req=4'b0011 held constantly → ch0 gets 4 cycles, ch1 gets 4 cycles, alternating. Same stimulus without the macro → ch0 holds indefinitely.
- Async reset mid-grant: assert reset between clock edges → grant=0 and state=00 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/match_count_arbiter.sv
// Round-robin arbiter sharing one match counter between NUM_REQ channels, with global halt.
// Optional feature: define MATCH_ARB_HOLD_LIMIT_EN to force a release after MAX_HOLD cycles.
module match_count_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_W     = 2,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               halt_flag,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic [1:0]         state,
    output logic               enable_count
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StMatch = 2'b01,
        StHalt  = 2'b10
    } state_e;

    if (NUM_REQ < 2 || NUM_REQ > 16 || (2 ** ID_W) < NUM_REQ || MAX_HOLD < 1) begin : g_bad_param
        $error("match_count_arbiter: illegal parameter combination");
    end

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic               enable_q;

    logic [ID_W-1:0]    rr_next;
    logic [ID_W-1:0]    rr_base;
    logic [ID_W-1:0]    rot_idx;
    logic [NUM_REQ-1:0] req_rot;
    logic               pick_found;
    int                 pick_off;
    logic [ID_W-1:0]    pick_id;
    logic               force_release;

    // In MATCH the search starts just past the current winner, i.e. the post-release pointer.
    assign rr_next = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
    assign rr_base = (state_q == StMatch) ? rr_next : rr_ptr_q;

    always_comb begin
        rot_idx    = '0;
        req_rot    = '0;
        pick_found = 1'b0;
        pick_off   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rot_idx    = ID_W'((int'(rr_base) + i) % int'(NUM_REQ));
            req_rot[i] = req[rot_idx];
        end
        // Scan downward so the smallest offset from the base wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick_found = 1'b1;
                pick_off   = i;
            end
        end
        pick_id = ID_W'((int'(rr_base) + pick_off) % int'(NUM_REQ));
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        unique case (state_q)
            StIdle: begin
                grant_d = '0;
                if (halt_flag) begin
                    state_d = StHalt;
                end else if (pick_found) begin
                    state_d    = StMatch;
                    grant_d    = NUM_REQ'(1) << pick_id;
                    grant_id_d = pick_id;
                end
            end
            StMatch: begin
                if (halt_flag) begin
                    state_d = StHalt;
                    grant_d = '0;
                end else if (!(|(req & grant_q)) || force_release) begin
                    rr_ptr_d = rr_next;
                    if (pick_found) begin
                        grant_d    = NUM_REQ'(1) << pick_id;
                        grant_id_d = pick_id;
                    end else begin
                        state_d = StIdle;
                        grant_d = '0;
                    end
                end
            end
            StHalt: begin
                grant_d = '0;
                if (!halt_flag) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            enable_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            enable_q   <= (state_d == StMatch);
        end
    end

`ifdef MATCH_ARB_HOLD_LIMIT_EN
    localparam int unsigned TenureW = $clog2(MAX_HOLD + 1);

    logic [TenureW-1:0] tenure_q, tenure_d;

    assign force_release = (tenure_q == TenureW'(MAX_HOLD)) && (|(req & ~grant_q));

    // A new grant always targets a different channel, so a grant change marks a fresh tenure.
    always_comb begin
        if (grant_d == '0) begin
            tenure_d = tenure_q;
        end else if (grant_d != grant_q) begin
            tenure_d = TenureW'(1);
        end else if (tenure_q != TenureW'(MAX_HOLD)) begin
            tenure_d = tenure_q + 1'b1;
        end else begin
            tenure_d = tenure_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tenure_q <= '0;
        end else begin
            tenure_q <= tenure_d;
        end
    end
`else
    assign force_release = 1'b0;
`endif

    assign grant        = grant_q;
    assign grant_id     = grant_id_q;
    assign state        = state_q;
    assign enable_count = enable_q;

endmodule
